// File: rtl/dbus_pio.sv
// -----------------------------------------------------------------------------
// dbus_pio : word-addressed data bus with data RAM, GPIO channels and a
//            down-counting timer with overflow interrupt.
//
// Address map (word addresses):
//   0x0000 .. RAM_DEPTH-1   data RAM (read/write, contents not reset)
//   0x2000 + 2k             GPIO_OUT[k] (read/write), drives gpio_out
//   0x2001 + 2k             GPIO_IN[k]  (read-only, two-flop synchronised)
//   0x2100                  CTRL   bit0 EN, bit1 AUTO, bit2 IE
//   0x2101                  LOAD   (a write also loads COUNT)
//   0x2102                  COUNT  (read-only)
//   0x2103                  STATUS bit0 OVF (write-one-to-clear)
//
// Ports:
//   clk       single rising-edge clock
//   rst       asynchronous active-high reset
//   din       write data (DW)
//   addr      word address (AW)
//   we        1 = write, 0 = read
//   dout      registered read data, holds during write cycles
//   gpio_in   GPIO_N packed input channels, channel k at [k*DW +: DW]
//   gpio_out  GPIO_N packed output channels, same packing
//   irq       registered timer interrupt (OVF and IE)
// -----------------------------------------------------------------------------
module dbus_pio #(
  parameter int DW        = 16,
  parameter int AW        = 16,
  parameter int RAM_DEPTH = 256,
  parameter int GPIO_N    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        din,
  input  logic [AW-1:0]        addr,
  input  logic                 we,
  output logic [DW-1:0]        dout,
  input  logic [GPIO_N*DW-1:0] gpio_in,
  output logic [GPIO_N*DW-1:0] gpio_out,
  output logic                 irq
);

  localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  localparam logic [AW-1:0] GPIO_BASE = AW'(32'h0000_2000);
  localparam logic [AW-1:0] CTRL_A    = AW'(32'h0000_2100);
  localparam logic [AW-1:0] LOAD_A    = AW'(32'h0000_2101);
  localparam logic [AW-1:0] COUNT_A   = AW'(32'h0000_2102);
  localparam logic [AW-1:0] STAT_A    = AW'(32'h0000_2103);

  // Storage and registers
  logic [DW-1:0]        mem_q [RAM_DEPTH];
  logic [DW-1:0]        dout_q;
  logic [GPIO_N*DW-1:0] gpo_q, gpo_d;
  logic [GPIO_N*DW-1:0] sync1_q, sync2_q;
  logic [2:0]           ctrl_q, ctrl_d;
  logic [DW-1:0]        load_q, load_d;
  logic [DW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 irq_q, irq_d;

  // Decode / datapath signals
  logic                 ram_hit_s;
  logic [RAM_AW-1:0]    ram_idx_s;
  logic [DW-1:0]        gpio_rdata_s;
  logic [DW-1:0]        rdata_s;
  logic                 wr_ctrl_s, wr_load_s, wr_stat_s;
  logic                 ovf_evt_s;

  // Full-width compare: addresses above RAM_DEPTH never alias into the RAM
  always_comb begin
    ram_hit_s = (32'(addr) < 32'(RAM_DEPTH));
    ram_idx_s = addr[RAM_AW-1:0];
    wr_ctrl_s = we && (addr == CTRL_A);
    wr_load_s = we && (addr == LOAD_A);
    wr_stat_s = we && (addr == STAT_A);
  end

  // GPIO channel decode: read mux and next-state of the output registers
  always_comb begin
    gpio_rdata_s = {DW{1'b0}};
    gpo_d        = gpo_q;
    for (int k = 0; k < GPIO_N; k++) begin
      gpio_rdata_s = gpio_rdata_s
                   | ((addr == GPIO_BASE + AW'(2*k))     ? gpo_q[k*DW +: DW]   : {DW{1'b0}})
                   | ((addr == GPIO_BASE + AW'(2*k + 1)) ? sync2_q[k*DW +: DW] : {DW{1'b0}});
      gpo_d[k*DW +: DW] = (we && (addr == GPIO_BASE + AW'(2*k))) ? din : gpo_q[k*DW +: DW];
    end
  end

  // Read data mux; anything not decoded returns zero
  always_comb begin
    rdata_s = {DW{1'b0}};
    if (ram_hit_s) begin
      rdata_s = mem_q[ram_idx_s];
    end else begin
      case (addr)
        CTRL_A:  rdata_s = DW'(ctrl_q);
        LOAD_A:  rdata_s = load_q;
        COUNT_A: rdata_s = count_q;
        STAT_A:  rdata_s = DW'(ovf_q);
        default: rdata_s = gpio_rdata_s;
      endcase
    end
  end

  // Timer next state. A LOAD write wins over decrement/reload for COUNT, and
  // a CTRL write wins over the one-shot EN clear; the OVF set still happens.
  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    ovf_evt_s = ctrl_q[0] && (count_q == {DW{1'b0}});

    if (wr_load_s) begin
      load_d  = din;
      count_d = din;
    end else if (ovf_evt_s) begin
      count_d = ctrl_q[1] ? load_q : {DW{1'b0}};
    end else if (ctrl_q[0]) begin
      count_d = count_q - DW'(1);
    end else begin
      count_d = count_q;
    end

    if (wr_ctrl_s) begin
      ctrl_d = din[2:0];
    end else if (ovf_evt_s && !ctrl_q[1]) begin
      ctrl_d = {ctrl_q[2:1], 1'b0};
    end else begin
      ctrl_d = ctrl_q;
    end

    // Set has priority over a coincident write-one-to-clear
    if (ovf_evt_s) begin
      ovf_d = 1'b1;
    end else if (wr_stat_s && din[0]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    irq_d = ovf_q & ctrl_q[2];
  end

  // RAM write port; array has no reset and writes are held off during reset
  always_ff @(posedge clk) begin
    if (!rst && we && ram_hit_s) begin
      mem_q[ram_idx_s] <= din;
    end
  end

  // Read data register; holds its value during write cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= {DW{1'b0}};
    end else if (!we) begin
      dout_q <= rdata_s;
    end else begin
      dout_q <= dout_q;
    end
  end

  // GPIO output registers and two-flop input synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpo_q   <= {(GPIO_N*DW){1'b0}};
      sync1_q <= {(GPIO_N*DW){1'b0}};
      sync2_q <= {(GPIO_N*DW){1'b0}};
    end else begin
      gpo_q   <= gpo_d;
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end

  // Timer registers and interrupt flop; reset aborts any count in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= 3'b000;
      load_q  <= {DW{1'b0}};
      count_q <= {DW{1'b0}};
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
    end
  end

  assign dout     = dout_q;
  assign gpio_out = gpo_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_dbus_pio.sv
// -----------------------------------------------------------------------------
// tb_dbus_pio : directed plus random test of dbus_pio against a behavioural
// model of the bus (RAM array, GPIO registers, synchroniser history, timer).
// -----------------------------------------------------------------------------
module tb_dbus_pio;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic [15:0] addr;
  logic        we;
  logic [15:0] dout;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  dbus_pio #(.DW(16), .AW(16), .RAM_DEPTH(256), .GPIO_N(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .addr     (addr),
    .we       (we),
    .dout     (dout),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [15:0] m_ram [256];
  bit          m_ram_ok [256];
  logic [31:0] m_gpo, m_s1, m_s2;
  bit          m_en, m_auto, m_ie, m_ovf, m_irq;
  logic [15:0] m_load, m_count;
  logic [15:0] m_dout;
  bit          m_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gpo = '0; m_s1 = '0; m_s2 = '0;
    m_en = 0; m_auto = 0; m_ie = 0; m_ovf = 0; m_irq = 0;
    m_load = '0; m_count = '0;
    m_dout = '0; m_known = 1;
  endtask

  function automatic logic [15:0] mread(input logic [15:0] a, output bit known);
    int k;
    known = 1;
    mread = 16'h0000;
    if (a < 256) begin
      known = m_ram_ok[a[7:0]];
      mread = m_ram[a[7:0]];
    end else if (a >= 16'h2000 && a < 16'h2004) begin
      k = (a - 16'h2000) / 2;
      mread = a[0] ? m_s2[k*16 +: 16] : m_gpo[k*16 +: 16];
    end else if (a == 16'h2100) mread = {13'd0, m_ie, m_auto, m_en};
    else if (a == 16'h2101) mread = m_load;
    else if (a == 16'h2102) mread = m_count;
    else if (a == 16'h2103) mread = {15'd0, m_ovf};
    else mread = 16'h0000;
  endfunction

  // One bus cycle: drive, advance the model across the edge, compare outputs
  task automatic step(input bit w, input logic [15:0] a, input logic [15:0] d);
    logic [15:0] rv;
    bit kn, fire, irq_n;
    we = w; addr = a; din = d;
    if (!w) begin
      rv = mread(a, kn);
      m_dout = rv;
      m_known = kn;
    end
    irq_n = m_ovf && m_ie;
    fire  = m_en && (m_count == 0);
    if (fire) begin
      m_ovf = 1;
      if (m_auto) m_count = m_load;
      else m_en = 0;
    end else if (m_en) begin
      m_count = m_count - 16'd1;
    end
    if (w) begin
      if (a < 256) begin m_ram[a[7:0]] = d; m_ram_ok[a[7:0]] = 1; end
      if (a == 16'h2000) m_gpo[15:0]  = d;
      if (a == 16'h2002) m_gpo[31:16] = d;
      if (a == 16'h2100) begin m_en = d[0]; m_auto = d[1]; m_ie = d[2]; end
      if (a == 16'h2101) begin m_load = d; m_count = d; end
      if (a == 16'h2103 && d[0] && !fire) m_ovf = 0;
    end
    m_irq = irq_n;
    m_s2 = m_s1;
    m_s1 = gpio_in;
    @(posedge clk);
    #1;
    if (m_known) chk("dout", {16'd0, dout}, {16'd0, m_dout});
    chk("gpio_out", gpio_out, m_gpo);
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  initial begin
    logic [15:0] ra, rd;
    rst = 1'b1; we = 1'b0; addr = 16'h0000; din = 16'h0000; gpio_in = 32'h0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", {16'd0, dout}, 32'h0);
    chk("rst_gpio_out", gpio_out, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    rst = 1'b0;
    step(0, 16'h2103, 16'h0000);
    chk("rst_status", {16'd0, dout}, 32'h0);

    // RAM write then read back; unwritten location not checked
    step(1, 16'h0000, 16'h0030);
    step(0, 16'h0000, 16'h0000);
    chk("ram_rd0", {16'd0, dout}, 32'h0030);
    step(0, 16'h0005, 16'h0000);

    // GPIO out and synchronised GPIO in
    step(1, 16'h2000, 16'h003C);
    chk("gpio_out0", {16'd0, gpio_out[15:0]}, 32'h003C);
    gpio_in = {16'h001A, 16'h0000};
    step(0, 16'h1FFF, 16'h0000);
    chk("unmapped_1fff", {16'd0, dout}, 32'h0);
    step(0, 16'h1FFF, 16'h0000);
    step(0, 16'h2003, 16'h0000);
    chk("gpio_in1", {16'd0, dout}, 32'h001A);

    // Read-only and out-of-range GPIO addresses
    step(1, 16'h2001, 16'hFFFF);
    step(0, 16'h2001, 16'h0000);
    chk("gpio_in0_ro", {16'd0, dout}, 32'h0);
    step(0, 16'h2004, 16'h0000);
    chk("gpio_2004", {16'd0, dout}, 32'h0);

    // One-shot timer
    step(1, 16'h2101, 16'h0003);
    step(1, 16'h2100, 16'h0005);
    step(0, 16'h2102, 16'h0000); chk("cnt3", {16'd0, dout}, 32'd3);
    step(0, 16'h2102, 16'h0000); chk("cnt2", {16'd0, dout}, 32'd2);
    step(0, 16'h2102, 16'h0000); chk("cnt1", {16'd0, dout}, 32'd1);
    step(0, 16'h2102, 16'h0000); chk("cnt0", {16'd0, dout}, 32'd0);
    chk("irq_not_yet", {31'd0, irq}, 32'd0);
    step(0, 16'h2103, 16'h0000); chk("ovf_set", {16'd0, dout}, 32'd1);
    chk("irq_set", {31'd0, irq}, 32'd1);
    step(0, 16'h2100, 16'h0000); chk("en_cleared", {16'd0, dout}, 32'd4);
    step(1, 16'h2103, 16'h0001);
    step(0, 16'h2103, 16'h0000); chk("ovf_w1c", {16'd0, dout}, 32'd0);
    chk("irq_clr", {31'd0, irq}, 32'd0);

    // Auto-reload: events every second cycle; w1c on an event keeps OVF
    step(1, 16'h2101, 16'h0001);
    step(1, 16'h2100, 16'h0007);
    step(0, 16'h2102, 16'h0000);
    step(0, 16'h2102, 16'h0000);
    step(1, 16'h2103, 16'h0001);
    step(1, 16'h2103, 16'h0001);
    step(0, 16'h2103, 16'h0000); chk("w1c_on_event", {16'd0, dout}, 32'd1);

    // Asynchronous reset in the middle of a count
    step(1, 16'h2101, 16'd100);
    step(1, 16'h2100, 16'h0005);
    step(0, 16'h2000, 16'h0000);
    chk("pre_rst_dout", {16'd0, dout}, 32'h003C);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_dout", {16'd0, dout}, 32'h0);
    chk("async_gpio_out", gpio_out, 32'h0);
    chk("async_irq", {31'd0, irq}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(0, 16'h2102, 16'h0000); chk("post_rst_count", {16'd0, dout}, 32'h0);
    step(0, 16'h2100, 16'h0000); chk("post_rst_ctrl", {16'd0, dout}, 32'h0);
    step(0, 16'h0000, 16'h0000); chk("ram_kept", {16'd0, dout}, 32'h0030);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0, 1: ra = 16'($urandom_range(0, 7));
        2:    ra = 16'h2000 + 16'($urandom_range(0, 4));
        3, 4, 5: ra = 16'h2100 + 16'($urandom_range(0, 3));
        6:    ra = 16'h1FFF;
        default: ra = 16'h3000 | 16'($urandom_range(0, 255));
      endcase
      rd = 16'($urandom);
      if (ra == 16'h2101) rd = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) gpio_in = $urandom;
      step(($urandom_range(0, 2) == 0), ra, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_pio.md
DBUS_PIO -- requirements
Module: dbus_pio

Interface
REQ-001 SHALL have parameter DW, default 16, data width in bits.
REQ-002 SHALL have parameter AW, default 16, address width in bits.
REQ-003 SHALL have parameter RAM_DEPTH, default 256, number of data RAM words; power of two, at most 2^13.
REQ-004 SHALL have parameter GPIO_N, default 2, number of GPIO channels, range 1..8.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port din, input, DW bits, write data.
REQ-008 SHALL have port addr, input, AW bits, word address.
REQ-009 SHALL have port we, input, 1 bit, write enable; 0 means a read access.
REQ-010 SHALL have port dout, output, DW bits, registered read data.
REQ-011 SHALL have port gpio_in, input, GPIO_N*DW bits, where channel k is bits [k*DW +: DW].
REQ-012 SHALL have port gpio_out, output, GPIO_N*DW bits, with the same channel packing as gpio_in.
REQ-013 SHALL have port irq, output, 1 bit, registered timer interrupt.

Function
REQ-014 SHALL map addresses 0x0000..RAM_DEPTH-1 to the data RAM.
REQ-015 SHALL map 0x2000+2k to GPIO_OUT[k] (read/write) and 0x2001+2k to GPIO_IN[k] (read-only), for k < GPIO_N.
REQ-016 SHALL map the timer registers as 0x2100 CTRL, 0x2101 LOAD, 0x2102 COUNT (read-only) and 0x2103 STATUS.
REQ-017 SHALL use CTRL bit0 = EN, bit1 = AUTO (auto-reload) and bit2 = IE (interrupt enable); the other CTRL bits read as 0.
REQ-018 SHALL ignore writes to unmapped or read-only addresses, and unmapped reads SHALL return 0.
REQ-019 SHALL perform writes on the rising edge of clk when we=1.
REQ-020 SHALL register read data so that dout is valid one cycle after the address is presented with we=0; dout holds its value during write cycles.
REQ-021 SHALL return the old value when a read immediately follows a write to the same address is NOT required: a read in cycle N+1 after a write in cycle N SHALL return the new value.
REQ-022 SHALL pass gpio_in through a two-flop synchroniser, so a GPIO_IN read reflects a pin value with 2 cycles of latency plus the 1-cycle read latency.
REQ-023 SHALL drive gpio_out directly from the GPIO_OUT registers.
REQ-024 SHALL, when a LOAD write occurs, also load COUNT with din in the same edge.
REQ-025 SHALL, while EN=1 and COUNT>0, decrement COUNT by 1 per cycle.
REQ-026 SHALL, on an edge where EN=1 and COUNT==0, set STATUS bit0 (OVF); then COUNT reloads from LOAD if AUTO=1, otherwise EN clears and COUNT stays at 0.
REQ-027 SHALL clear STATUS bit0 when a 1 is written to it (write-one-to-clear); if that write coincides with an OVF event, the set takes priority.
REQ-028 SHALL give a LOAD write priority over a decrement or reload in the same cycle.
REQ-029 SHALL register irq as OVF AND IE, one cycle after OVF changes.
REQ-030 SHALL compute address decode with AW-bit compares only; the upper address bits are not aliased.

Reset
REQ-031 SHALL, while rst=1 (asynchronous), force dout, gpio_out, CTRL, LOAD, COUNT, STATUS, irq and both synchroniser stages to 0.
REQ-032 SHALL leave RAM contents uninitialised by reset, and SHALL NOT perform writes while rst=1.
REQ-033 SHALL, on reset assertion mid-count, immediately abort the count with COUNT=0 and EN=0.

Verification
REQ-034 SHALL cover RAM access: write 0x0030 at address 0x0000, then read 0x0000 -> dout=0x0030 on the following cycle; read 0x0005 after reset with no prior write -> value not checked.
REQ-035 SHALL cover GPIO: write 0x003C at 0x2000 -> gpio_out[15:0]=0x003C on the next cycle; drive gpio_in channel 1 = 0x001A, wait 2 cycles, read 0x2003 -> dout=0x001A.
REQ-036 SHALL cover one-shot timer: LOAD=3, CTRL=0x5 -> COUNT sequence 3,2,1,0; OVF set, EN cleared, irq=1 one cycle later; write 1 to 0x2103 -> irq=0.
REQ-037 SHALL cover auto-reload: LOAD=1, CTRL=0x7 -> OVF events every 2 cycles; a w1c write on an event cycle leaves OVF=1.
REQ-038 SHALL cover unmapped and read-only access: read 0x1FFF -> 0; write to 0x2001 -> GPIO_IN unchanged; with GPIO_N=2, address 0x2004 reads 0.
REQ-039 SHALL cover async reset: assert rst mid-count between clock edges -> all outputs 0 before the next edge.
